id_ex_operand_stage: RTL and testbench

ID/EX operand stage that sits directly downstream of the 32×32 register file (read ports PA/PB, addresses RA/RB). It resolves operand hazards by forwarding from the EX, MEM and WB stages and detects load-use hazards. On a load-use hazard it stalls the front end and inserts a bubble. It registers the selected operands and the destination control into the EX stage.

---
 rtl/pa_pipe_pkg.sv | 29 ++
 rtl/id_ex_operand_stage_if.sv | 56 +++++
 rtl/operand_forward_mux.sv | 62 ++++++
 rtl/id_ex_operand_stage.sv | 109 ++++++++++
 tb/tb_id_ex_operand_stage.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/pa_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pa_pipe_pkg
// Purpose  : Shared pipeline constants for the ID/EX operand stage:
//            forward-select codes, datapath/address width defaults and
//            the bubble values loaded into the EX registers.
// Revision : 1.0  initial release
// ============================================================================
package pa_pipe_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int AW_DEFAULT = 5;

  // Forward-select codes, also visible on the debug outputs.
  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  // A bubble is a no-op: no write, not a load, r0 destination, zero operands.
  localparam logic                  BUBBLE_LE   = 1'b0;
  localparam logic                  BUBBLE_LOAD = 1'b0;
  localparam logic [AW_DEFAULT-1:0] BUBBLE_RD   = '0;
  localparam logic [DW_DEFAULT-1:0] BUBBLE_DATA = '0;

endpackage
`default_nettype wire

// File: rtl/id_ex_operand_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage_if
// Purpose  : Bundle of ID-side, producer-side and EX-side signals for the
//            ID/EX operand stage.
// Ports    : master - drives register file data, ID controls, flush and
//                     producer results; observes the EX registers.
//            slave  - the operand stage itself.
// Revision : 1.0  initial release
// ============================================================================
interface id_ex_operand_stage_if #(
  parameter int DW = pa_pipe_pkg::DW_DEFAULT,
  parameter int AW = pa_pipe_pkg::AW_DEFAULT
);
  // ID stage
  logic [DW-1:0] pa;
  logic [DW-1:0] pb;
  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [AW-1:0] rd_id;
  logic          rf_le_id;
  logic          load_id;
  logic          use_a_id;
  logic          use_b_id;
  logic          flush;
  // Producers
  logic [DW-1:0] ex_result;
  logic [DW-1:0] mem_result;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] mem_rd;
  logic [AW-1:0] wb_rd;
  logic          mem_le;
  logic          wb_le;
  // EX stage and debug
  logic [DW-1:0] a_ex;
  logic [DW-1:0] b_ex;
  logic [AW-1:0] rd_ex;
  logic          rf_le_ex;
  logic          load_ex;
  logic [1:0]    fwd_a;
  logic [1:0]    fwd_b;
  logic          stall;

  modport master (
    output pa, pb, ra, rb, rd_id, rf_le_id, load_id, use_a_id, use_b_id, flush,
    output ex_result, mem_result, wb_data, mem_rd, wb_rd, mem_le, wb_le,
    input  a_ex, b_ex, rd_ex, rf_le_ex, load_ex, fwd_a, fwd_b, stall
  );

  modport slave (
    input  pa, pb, ra, rb, rd_id, rf_le_id, load_id, use_a_id, use_b_id, flush,
    input  ex_result, mem_result, wb_data, mem_rd, wb_rd, mem_le, wb_le,
    output a_ex, b_ex, rd_ex, rf_le_ex, load_ex, fwd_a, fwd_b, stall
  );
endinterface
`default_nettype wire

// File: rtl/operand_forward_mux.sv
`default_nettype none
// ============================================================================
// Module   : operand_forward_mux
// Purpose  : Priority compare of one source address against the EX, MEM and
//            WB destinations, then a 4:1 operand select with an r0 override.
// Ports    : src               - source register address
//            rf_data           - register file read data for src
//            ex_*/mem_*/wb_*   - producer enable, destination and data
//            fwd_sel           - selected source (RF/EX/MEM/WB)
//            operand           - forwarded operand
// Revision : 1.0  initial release
// ============================================================================
module operand_forward_mux
  import pa_pipe_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic [AW-1:0] src,
  input  logic [DW-1:0] rf_data,
  input  logic          ex_le,
  input  logic [AW-1:0] ex_rd,
  input  logic [DW-1:0] ex_data,
  input  logic          mem_le,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  input  logic          wb_le,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic [1:0]    fwd_sel,
  output logic [DW-1:0] operand
);

  logic w_src_zero;
  assign w_src_zero = (src == '0);

  always_comb begin
    fwd_sel = FWD_RF;
    // r0 is hard-wired to zero, so no producer can ever supply it.
    if (!w_src_zero) begin
      if (ex_le && (ex_rd == src)) begin
        fwd_sel = FWD_EX;
      end else if (mem_le && (mem_rd == src)) begin
        fwd_sel = FWD_MEM;
      end else if (wb_le && (wb_rd == src)) begin
        fwd_sel = FWD_WB;
      end
    end
  end

  always_comb begin
    operand = '0;
    case (fwd_sel)
      FWD_EX:  operand = ex_data;
      FWD_MEM: operand = mem_data;
      FWD_WB:  operand = wb_data;
      default: operand = w_src_zero ? '0 : rf_data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_operand_stage
// Purpose  : ID/EX operand stage. Forwards operands from EX/MEM/WB, detects
//            load-use hazards (stall + bubble), squashes on flush and
//            registers operands and destination control into EX.
// Ports    : clk   - rising-edge clock
//            rst_n - asynchronous active-low reset (bubble state)
//            bus   - ID inputs, producer results, EX registers, debug selects
// Revision : 1.0  initial release
// ============================================================================
module id_ex_operand_stage
  import pa_pipe_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  id_ex_operand_stage_if.slave  bus
);

  logic [DW-1:0] r_a_ex;
  logic [DW-1:0] r_b_ex;
  logic [AW-1:0] r_rd_ex;
  logic          r_rf_le_ex;
  logic          r_load_ex;

  logic [DW-1:0] w_a_fwd;
  logic [DW-1:0] w_b_fwd;
  logic [1:0]    w_fwd_a;
  logic [1:0]    w_fwd_b;
  logic          w_ex_fwd_le;
  logic          w_stall;

  // A load in EX has no data yet; it may only be picked up from MEM.
  assign w_ex_fwd_le = r_rf_le_ex && !r_load_ex;

  operand_forward_mux #(.DW(DW), .AW(AW)) u_fwd_a (
    .src      (bus.ra),
    .rf_data  (bus.pa),
    .ex_le    (w_ex_fwd_le),
    .ex_rd    (r_rd_ex),
    .ex_data  (bus.ex_result),
    .mem_le   (bus.mem_le),
    .mem_rd   (bus.mem_rd),
    .mem_data (bus.mem_result),
    .wb_le    (bus.wb_le),
    .wb_rd    (bus.wb_rd),
    .wb_data  (bus.wb_data),
    .fwd_sel  (w_fwd_a),
    .operand  (w_a_fwd)
  );

  operand_forward_mux #(.DW(DW), .AW(AW)) u_fwd_b (
    .src      (bus.rb),
    .rf_data  (bus.pb),
    .ex_le    (w_ex_fwd_le),
    .ex_rd    (r_rd_ex),
    .ex_data  (bus.ex_result),
    .mem_le   (bus.mem_le),
    .mem_rd   (bus.mem_rd),
    .mem_data (bus.mem_result),
    .wb_le    (bus.wb_le),
    .wb_rd    (bus.wb_rd),
    .wb_data  (bus.wb_data),
    .fwd_sel  (w_fwd_b),
    .operand  (w_b_fwd)
  );

  // Load-use hazard. A flushed ID instruction is discarded anyway, so holding
  // the front end for it would only waste a cycle.
  assign w_stall = !bus.flush && r_load_ex && r_rf_le_ex && (r_rd_ex != '0) &&
                   ((bus.use_a_id && (r_rd_ex == bus.ra)) ||
                    (bus.use_b_id && (r_rd_ex == bus.rb)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_ex     <= BUBBLE_DATA;
      r_b_ex     <= BUBBLE_DATA;
      r_rd_ex    <= BUBBLE_RD;
      r_rf_le_ex <= BUBBLE_LE;
      r_load_ex  <= BUBBLE_LOAD;
    end else if (bus.flush || w_stall) begin
      r_a_ex     <= BUBBLE_DATA;
      r_b_ex     <= BUBBLE_DATA;
      r_rd_ex    <= BUBBLE_RD;
      r_rf_le_ex <= BUBBLE_LE;
      r_load_ex  <= BUBBLE_LOAD;
    end else begin
      r_a_ex     <= w_a_fwd;
      r_b_ex     <= w_b_fwd;
      r_rd_ex    <= bus.rd_id;
      r_rf_le_ex <= bus.rf_le_id;
      r_load_ex  <= bus.load_id;
    end
  end

  assign bus.a_ex     = r_a_ex;
  assign bus.b_ex     = r_b_ex;
  assign bus.rd_ex    = r_rd_ex;
  assign bus.rf_le_ex = r_rf_le_ex;
  assign bus.load_ex  = r_load_ex;
  assign bus.fwd_a    = w_fwd_a;
  assign bus.fwd_b    = w_fwd_b;
  assign bus.stall    = w_stall;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_operand_stage
// Purpose  : Self-checking bench for id_ex_operand_stage. Directed vectors
//            push expected stall/forward selects and next-edge EX register
//            values into a queue; a monitor pops and compares.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_operand_stage;

  typedef struct {
    bit          chk_fwd;
    logic        stall;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        le;
    logic        ld;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  exp_t q[$];

  id_ex_operand_stage_if #(.DW(32), .AW(5)) bus ();

  id_ex_operand_stage #(.DW(32), .AW(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout act=running req=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push(input bit cf, input logic st, input logic [1:0] fa, input logic [1:0] fb,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                      input logic le, input logic ld);
    exp_t e;
    e.chk_fwd = cf; e.stall = st; e.fa = fa; e.fb = fb;
    e.a = a; e.b = b; e.rd = rd; e.le = le; e.ld = ld;
    q.push_back(e);
  endtask

  task automatic clear();
    bus.pa = '0; bus.pb = '0; bus.ra = '0; bus.rb = '0; bus.rd_id = '0;
    bus.rf_le_id = 1'b0; bus.load_id = 1'b0; bus.use_a_id = 1'b0; bus.use_b_id = 1'b0;
    bus.flush = 1'b0; bus.ex_result = '0; bus.mem_result = '0; bus.wb_data = '0;
    bus.mem_rd = '0; bus.wb_rd = '0; bus.mem_le = 1'b0; bus.wb_le = 1'b0;
  endtask

  task automatic id_ctl(input logic [4:0] rd, input logic le, input logic ld);
    bus.rd_id = rd; bus.rf_le_id = le; bus.load_id = ld;
  endtask

  // Monitor: combinational view mid-cycle, registered view just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("stall", 32'(bus.stall), 32'(e.stall));
        if (e.chk_fwd) begin
          chk("fwd_a", 32'(bus.fwd_a), 32'(e.fa));
          chk("fwd_b", 32'(bus.fwd_b), 32'(e.fb));
        end
        @(posedge clk);
        #1;
        chk("a_ex", bus.a_ex, e.a);
        chk("b_ex", bus.b_ex, e.b);
        chk("rd_ex", 32'(bus.rd_ex), 32'(e.rd));
        chk("rf_le_ex", 32'(bus.rf_le_ex), 32'(e.le));
        chk("load_ex", 32'(bus.load_ex), 32'(e.ld));
      end
    end
  end

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    clear();

    // Reset with random inputs: bubble state, no stall.
    repeat (2) begin
      @(negedge clk);
      bus.pa = $urandom; bus.pb = $urandom; bus.ra = 5'($urandom); bus.rb = 5'($urandom);
      bus.rd_id = 5'($urandom); bus.rf_le_id = 1'($urandom); bus.load_id = 1'($urandom);
      bus.use_a_id = 1'b1; bus.use_b_id = 1'b1; bus.flush = 1'($urandom);
      bus.mem_le = 1'($urandom); bus.wb_le = 1'($urandom);
      bus.mem_rd = 5'($urandom); bus.wb_rd = 5'($urandom);
      push(0, 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Release: first edge captures register file data.
    @(negedge clk); rst_n = 1'b1; clear();
    bus.ra = 1; bus.pa = 32'h1111_1111; bus.rb = 2; bus.pb = 32'h2222_2222;
    bus.use_a_id = 1; bus.use_b_id = 1; id_ctl(1, 1, 0);
    push(1, 0, 0, 0, 32'h1111_1111, 32'h2222_2222, 1, 1, 0);

    // Set up r3 as the EX destination (EX holds r1, unrelated to r5/r6).
    @(negedge clk); clear();
    bus.ra = 5; bus.pa = 10; bus.rb = 6; bus.pb = 20; id_ctl(3, 1, 0);
    push(1, 0, 0, 0, 10, 20, 3, 1, 0);

    // EX forward beats a matching MEM; rb=0 forces B to zero.
    @(negedge clk); clear();
    bus.ra = 3; bus.pa = 0; bus.ex_result = 32'hDEAD_BEEF;
    bus.mem_le = 1; bus.mem_rd = 3; bus.mem_result = 32'h0000_0123;
    bus.rb = 0; bus.pb = 77; id_ctl(0, 0, 0);
    push(1, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);

    // MEM beats WB on B.
    @(negedge clk); clear();
    bus.rb = 7; bus.pb = 100; bus.ra = 2; bus.pa = 44;
    bus.mem_le = 1; bus.mem_rd = 7; bus.mem_result = 5;
    bus.wb_le = 1; bus.wb_rd = 7; bus.wb_data = 9; id_ctl(8, 1, 0);
    push(1, 0, 0, 2, 44, 5, 8, 1, 0);

    // MEM disabled -> WB on B; A picks up r8 from EX.
    @(negedge clk); clear();
    bus.rb = 7; bus.pb = 100; bus.ra = 8; bus.pa = 44; bus.ex_result = 32'hAAAA_5555;
    bus.mem_le = 0; bus.mem_rd = 7; bus.mem_result = 5;
    bus.wb_le = 1; bus.wb_rd = 7; bus.wb_data = 9; id_ctl(0, 0, 0);
    push(1, 0, 1, 3, 32'hAAAA_5555, 9, 0, 0, 0);

    // r0 never forwards and reads as zero.
    @(negedge clk); clear();
    bus.ra = 0; bus.pa = 32'h0000_1234; bus.wb_le = 1; bus.wb_rd = 0;
    bus.wb_data = 32'hFFFF_FFFF; bus.rb = 9; bus.pb = 99;
    push(1, 0, 0, 0, 0, 99, 0, 0, 0);

    // Load to r4 enters EX.
    @(negedge clk); clear(); id_ctl(4, 1, 1);
    push(1, 0, 0, 0, 0, 0, 4, 1, 1);

    // ID reads r4 on B: stall, bubble, no EX forward from a load.
    @(negedge clk); clear();
    bus.ra = 1; bus.pa = 66; bus.rb = 4; bus.pb = 55; bus.use_a_id = 1; bus.use_b_id = 1;
    bus.ex_result = 32'h0000_0BAD; id_ctl(10, 1, 0);
    push(1, 1, 0, 0, 0, 0, 0, 0, 0);

    // Replay: load now in MEM, stall gone, B comes from MEM.
    @(negedge clk); clear();
    bus.ra = 1; bus.pa = 66; bus.rb = 4; bus.pb = 55; bus.use_a_id = 1; bus.use_b_id = 1;
    bus.mem_le = 1; bus.mem_rd = 4; bus.mem_result = 32'hCAFE_F00D; id_ctl(10, 1, 0);
    push(1, 0, 0, 2, 66, 32'hCAFE_F00D, 10, 1, 0);

    // Load to r5, then a dependent instruction that is flushed.
    @(negedge clk); clear(); id_ctl(5, 1, 1);
    push(1, 0, 0, 0, 0, 0, 5, 1, 1);
    @(negedge clk); clear();
    bus.ra = 5; bus.pa = 3; bus.use_a_id = 1; bus.flush = 1; id_ctl(11, 1, 0);
    push(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Load to r6, then a dependent read with reset asserted mid-stall.
    @(negedge clk); clear(); id_ctl(6, 1, 1);
    push(1, 0, 0, 0, 0, 0, 6, 1, 1);
    @(negedge clk); clear();
    bus.rb = 6; bus.pb = 12; bus.use_b_id = 1; id_ctl(12, 1, 0);
    push(1, 1, 0, 0, 0, 0, 0, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("load_ex_async_rst", 32'(bus.load_ex), 32'd0);
    chk("stall_async_rst", 32'(bus.stall), 32'd0);

    @(negedge clk); rst_n = 1'b1; clear();
    push(1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Drain the scoreboard, bounded.
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain act=%0d req=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
